// File: rtl/trng_sample_ctrl.sv
// Sequencer for the ring-oscillator TRNG: warm-up, decimated sampling, byte packing,
// TX handshake, and a repetition-count health test that aborts a stuck source.
module trng_sample_ctrl #(
    parameter int DIV_W      = 8,
    parameter int WARMUP_CYC = 256,
    parameter int RCT_LIMIT  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_rnd_bit,
    output logic             o_ro_en,
    input  logic             i_cmd_valid,
    input  logic [7:0]       i_cmd_data,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tx_valid,
    output logic [7:0]       o_tx_data,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_fault
);

    localparam int                WARM_W    = $clog2(WARMUP_CYC + 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_CYC - 1);
    localparam logic [7:0]        RCT_MAX   = 8'(RCT_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        COLLECT,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [7:0]        n_cnt;
    logic [DIV_W-1:0]  div_lat;
    logic [DIV_W-1:0]  div_cnt;
    logic [WARM_W-1:0] warm_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        run_cnt;
    logic [7:0]        run_next;
    logic              prev_bit;
    logic              fault;
    logic              strobe;
    logic              cmd_accept;
    logic              tx_xfer;
    logic              rct_fail;

    assign strobe     = (state == COLLECT) && (div_cnt == div_lat);
    assign cmd_accept = (state == IDLE) && i_en && i_cmd_valid && (i_cmd_data != 8'd0);
    assign tx_xfer    = (state == SEND) && i_tx_ready;
    assign rct_fail   = strobe && (run_next == RCT_MAX);

    // A cleared tracker (run_cnt == 0) means no previous sample exists yet in this command.
    always_comb begin
        run_next = run_cnt;
        if (run_cnt == 8'd0 || i_rnd_bit != prev_bit) begin
            run_next = 8'd1;
        end else if (run_cnt != 8'hFF) begin
            run_next = run_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!i_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_accept) state_next = WARMUP;
                end
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) state_next = COLLECT;
                end
                COLLECT: begin
                    // A health failure wins over completing the byte.
                    if (rct_fail) begin
                        state_next = IDLE;
                    end else if (strobe && bit_cnt == 3'd7) begin
                        state_next = SEND;
                    end
                end
                SEND: begin
                    if (tx_xfer) state_next = (n_cnt == 8'd1) ? IDLE : COLLECT;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ro_en    = 1'b0;
        o_busy     = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'd0;
        if (state != IDLE) begin
            o_ro_en = 1'b1;
            o_busy  = 1'b1;
        end
        if (state == SEND) begin
            o_tx_valid = 1'b1;
            o_tx_data  = shreg;
        end
    end

    assign o_fault = fault;

    // Divider and warm-up counters idle at zero so every COLLECT entry starts a fresh period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_cnt    <= 8'd0;
            div_lat  <= '0;
            div_cnt  <= '0;
            warm_cnt <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            run_cnt  <= 8'd0;
            prev_bit <= 1'b0;
            fault    <= 1'b0;
        end else begin
            if (cmd_accept) begin
                n_cnt    <= i_cmd_data;
                div_lat  <= i_div;
                fault    <= 1'b0;
                bit_cnt  <= 3'd0;
                run_cnt  <= 8'd0;
                prev_bit <= 1'b0;
            end

            if (state == WARMUP && state_next == WARMUP) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end else begin
                warm_cnt <= '0;
            end

            if (state == COLLECT && state_next == COLLECT) begin
                div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
            end else begin
                div_cnt <= '0;
            end

            if (strobe && i_en) begin
                shreg    <= {shreg[6:0], i_rnd_bit};
                prev_bit <= i_rnd_bit;
                run_cnt  <= run_next;
                bit_cnt  <= bit_cnt + 3'd1;
            end

            if (rct_fail && i_en) begin
                fault <= 1'b1;
            end

            if (tx_xfer && i_en) begin
                n_cnt <= n_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_trng_sample_ctrl.sv
// Bench for trng_sample_ctrl: table of byte-count runs plus hand-written corner sequences;
// every transferred byte is matched against a queue of expected bytes.
module tb_trng_sample_ctrl;

    localparam int WARMUP_CYC = 256;
    localparam int RCT_LIMIT  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic       i_rnd_bit;
    logic       o_ro_en;
    logic       i_cmd_valid;
    logic [7:0] i_cmd_data;
    logic [7:0] i_div;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_ready;
    logic       o_busy;
    logic       o_fault;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] n;
        logic [7:0] div;
        logic [7:0] pat;
    } vec_t;

    vec_t vecs[6];

    trng_sample_ctrl #(
        .DIV_W(8),
        .WARMUP_CYC(WARMUP_CYC),
        .RCT_LIMIT(RCT_LIMIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_en(i_en),
        .i_rnd_bit(i_rnd_bit),
        .o_ro_en(o_ro_en),
        .i_cmd_valid(i_cmd_valid),
        .i_cmd_data(i_cmd_data),
        .i_div(i_div),
        .o_tx_valid(o_tx_valid),
        .o_tx_data(o_tx_data),
        .i_tx_ready(i_tx_ready),
        .o_busy(o_busy),
        .o_fault(o_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] n, input logic [7:0] div);
        i_cmd_valid = 1'b1;
        i_cmd_data  = n;
        i_div       = div;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd_data  = 8'd0;
    endtask

    // Starts just after the edge that enters COLLECT; ends just after the edge that raises valid.
    task automatic driveByte(input logic [7:0] pat, input int div, input bit push);
        if (push) sb.push_back(pat);
        for (int k = 0; k < 8; k++) begin
            i_rnd_bit = pat[7-k];
            repeat (div) tick();
            if (k == 7) checkOutput("valid_early", 32'(o_tx_valid), 32'd0);
            tick();
        end
        checkOutput("valid_rise", 32'(o_tx_valid), 32'd1);
        checkOutput("data_at_valid", 32'(o_tx_data), 32'(pat));
        checkOutput("busy_in_send", 32'(o_busy), 32'd1);
    endtask

    task automatic runVector(input vec_t v);
        applyStimulus(v.n, v.div);
        checkOutput("busy_accept", 32'(o_busy), 32'd1);
        repeat (WARMUP_CYC - 1) tick();
        checkOutput("ro_en_warmup", 32'(o_ro_en), 32'd1);
        checkOutput("valid_warmup", 32'(o_tx_valid), 32'd0);
        tick();
        for (int b = 0; b < int'(v.n); b++) begin
            driveByte(v.pat, int'(v.div), 1'b1);
            tick();
        end
        checkOutput("busy_done", 32'(o_busy), 32'd0);
        checkOutput("ro_en_done", 32'(o_ro_en), 32'd0);
        checkOutput("valid_done", 32'(o_tx_valid), 32'd0);
    endtask

    // Stuck-at-1 source: three full bytes, then the 32nd strobe trips the health test.
    task automatic stuckRun();
        i_rnd_bit = 1'b1;
        applyStimulus(8'd8, 8'd0);
        repeat (3) sb.push_back(8'hFF);
        repeat (WARMUP_CYC) tick();
        repeat (34) tick();
        checkOutput("fault_before_32", 32'(o_fault), 32'd0);
        tick();
        checkOutput("fault_at_32", 32'(o_fault), 32'd1);
        checkOutput("busy_after_fault", 32'(o_busy), 32'd0);
        checkOutput("ro_en_after_fault", 32'(o_ro_en), 32'd0);
        checkOutput("valid_after_fault", 32'(o_tx_valid), 32'd0);
        repeat (20) tick();
        checkOutput("no_fourth_byte", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && o_tx_valid && i_tx_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no transfer at %0t",
                         o_tx_data, $time);
            end else begin
                checkOutput("tx_byte", 32'(o_tx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        vecs[0] = '{n: 8'd2, div: 8'd3,   pat: 8'hAA};
        vecs[1] = '{n: 8'd1, div: 8'd0,   pat: 8'h59};
        vecs[2] = '{n: 8'd3, div: 8'd1,   pat: 8'h3A};
        vecs[3] = '{n: 8'd1, div: 8'd7,   pat: 8'hC1};
        vecs[4] = '{n: 8'd2, div: 8'd2,   pat: 8'h96};
        vecs[5] = '{n: 8'd1, div: 8'd255, pat: 8'h69};

        i_en        = 1'b1;
        i_rnd_bit   = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_data  = 8'd0;
        i_div       = 8'd0;
        i_tx_ready  = 1'b1;
        rst_n       = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_ro_en", 32'(o_ro_en), 32'd0);
        checkOutput("rst_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("rst_fault", 32'(o_fault), 32'd0);
        checkOutput("rst_data", 32'(o_tx_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i]);
            repeat (3) tick();
        end

        // Back-pressure: byte must hold while ready is low and the source keeps toggling.
        i_tx_ready = 1'b0;
        applyStimulus(8'd1, 8'd1);
        repeat (WARMUP_CYC) tick();
        driveByte(8'hB4, 1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            i_rnd_bit = ~i_rnd_bit;
            tick();
            checkOutput("hold_valid", 32'(o_tx_valid), 32'd1);
            checkOutput("hold_data", 32'(o_tx_data), 32'hB4);
        end
        i_tx_ready = 1'b1;
        tick();
        checkOutput("busy_after_hold", 32'(o_busy), 32'd0);
        checkOutput("sb_after_hold", 32'(sb.size()), 32'd0);

        stuckRun();

        // Ignored commands, then fault cleared by the next accepted one.
        applyStimulus(8'd0, 8'd3);
        checkOutput("cmd_zero_ignored", 32'(o_busy), 32'd0);
        checkOutput("fault_sticky", 32'(o_fault), 32'd1);
        i_en = 1'b0;
        applyStimulus(8'd2, 8'd0);
        checkOutput("cmd_en_low_ignored", 32'(o_busy), 32'd0);
        i_en = 1'b1;
        applyStimulus(8'd1, 8'd0);
        checkOutput("fault_cleared", 32'(o_fault), 32'd0);
        checkOutput("busy_new_cmd", 32'(o_busy), 32'd1);
        applyStimulus(8'd5, 8'd0);
        repeat (WARMUP_CYC - 1) tick();
        driveByte(8'h4D, 0, 1'b1);
        tick();
        checkOutput("busy_cmd_ignored", 32'(o_busy), 32'd0);

        // Enable dropped after five strobes: abort with no byte and fault untouched.
        applyStimulus(8'd3, 8'd1);
        repeat (WARMUP_CYC) tick();
        for (int k = 0; k < 5; k++) begin
            i_rnd_bit = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            repeat (2) tick();
        end
        checkOutput("busy_before_abort", 32'(o_busy), 32'd1);
        i_en = 1'b0;
        tick();
        checkOutput("abort_busy", 32'(o_busy), 32'd0);
        checkOutput("abort_ro_en", 32'(o_ro_en), 32'd0);
        checkOutput("abort_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("abort_fault", 32'(o_fault), 32'd0);
        i_en = 1'b1;
        repeat (40) tick();
        checkOutput("abort_stays_idle", 32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of SEND.
        i_tx_ready = 1'b0;
        applyStimulus(8'd1, 8'd0);
        repeat (WARMUP_CYC) tick();
        driveByte(8'h21, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(o_tx_valid), 32'd0);
        checkOutput("async_rst_ro_en", 32'(o_ro_en), 32'd0);
        checkOutput("async_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("async_rst_fault", 32'(o_fault), 32'd0);
        tick();
        rst_n = 1'b1;
        i_tx_ready = 1'b1;
        repeat (3) tick();
        checkOutput("idle_after_rst", 32'(o_busy), 32'd0);

        // Reset must also clear a sticky fault without waiting for a clock edge.
        stuckRun();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_clears_fault", 32'(o_fault), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();

        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
